// File: rtl/input_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : input_scheduler
// Brief   : Frame-paced key/gravity command scheduler issuing up to MAX_CMDS
//           commands per frame over valid/ready. Optional macro AUTO_REPEAT_EN
//           adds held-key auto-repeat for DROP, LEFT and RIGHT.
// Revision: 1.0 - initial release
// ============================================================================
module input_scheduler #(
    parameter int MOVE_DELAY    = 30,
    parameter int MAX_CMDS      = 2
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 6
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] op_keys,
    input  logic       draw_finish,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic       busy,
    output logic       frame_overrun
);

    localparam logic [2:0] CMD_NONE    = 3'd0;
    localparam logic [2:0] CMD_GRAVITY = 3'd1;
    localparam logic [2:0] CMD_DROP    = 3'd2;
    localparam logic [2:0] CMD_ROTATE  = 3'd3;
    localparam logic [2:0] CMD_LEFT    = 3'd4;
    localparam logic [2:0] CMD_RIGHT   = 3'd5;
    localparam logic [7:0] WRAP_AT     = 8'(MOVE_DELAY - 1);
    localparam logic [3:0] MAX_ISSUED  = 4'(MAX_CMDS);

    typedef enum logic [1:0] {IDLE = 2'd0, SELECT = 2'd1, ISSUE = 2'd2} state_t;

    state_t     state;
    logic [3:0] key_prev, pend, key_edge, rep_set, key_set, key_clr, cand;
    logic       pend_grav, grav_set, grav_clr, cand_grav, accept;
    logic [7:0] frame_cnt;
    logic [3:0] issued;
    logic [2:0] sel_code;

    assign key_edge  = op_keys & ~key_prev;
    assign key_set   = key_edge | rep_set;
    assign grav_set  = draw_finish && (frame_cnt == WRAP_AT);
    assign accept    = cmd_valid & cmd_ready;
    assign grav_clr  = accept && (cmd_code == CMD_GRAVITY);
    assign key_clr   = {accept && (cmd_code == CMD_RIGHT),
                        accept && (cmd_code == CMD_LEFT),
                        accept && (cmd_code == CMD_DROP),
                        accept && (cmd_code == CMD_ROTATE)};
    // Same-cycle sets are visible to SELECT, not just the registered bits.
    assign cand      = pend | key_set;
    assign cand_grav = pend_grav | grav_set;
    assign busy      = (state != IDLE);

    always_comb begin
        sel_code = CMD_NONE;
        if (cand_grav)    sel_code = CMD_GRAVITY;
        else if (cand[1]) sel_code = CMD_DROP;
        else if (cand[0]) sel_code = CMD_ROTATE;
        else if (cand[2]) sel_code = CMD_LEFT;
        else if (cand[3]) sel_code = CMD_RIGHT;
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [4:0] REP_LAST = 5'(REPEAT_FRAMES);

    assign rep_set[0] = 1'b0;
    for (genvar k = 1; k < 4; k++) begin : g_repeat
        logic [4:0] rep_cnt;
        logic       hit;
        assign hit        = draw_finish && op_keys[k] && key_prev[k] &&
                            ((rep_cnt + 5'd1) == REP_LAST);
        assign rep_set[k] = hit;
        always_ff @(posedge clk) begin
            if (rst || !op_keys[k] || key_edge[k]) rep_cnt <= 5'd0;
            else if (draw_finish)                  rep_cnt <= hit ? 5'd0 : rep_cnt + 5'd1;
        end
    end
`else
    assign rep_set = 4'b0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            key_prev      <= 4'b0000;
            pend          <= 4'b0000;
            pend_grav     <= 1'b0;
            frame_cnt     <= 8'd0;
            issued        <= 4'd0;
            cmd_valid     <= 1'b0;
            cmd_code      <= CMD_NONE;
            frame_overrun <= 1'b0;
        end else begin
            key_prev  <= op_keys;
            pend      <= (pend & ~key_clr) | key_set;
            pend_grav <= (pend_grav & ~grav_clr) | grav_set;
            if (draw_finish)
                frame_cnt <= (frame_cnt == WRAP_AT) ? 8'd0 : frame_cnt + 8'd1;
            if (draw_finish && state != IDLE)
                frame_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (draw_finish) begin
                        state  <= SELECT;
                        issued <= 4'd0;
                    end
                end
                SELECT: begin
                    if (sel_code == CMD_NONE || issued >= MAX_ISSUED) begin
                        state <= IDLE;
                    end else begin
                        cmd_code  <= sel_code;
                        cmd_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        cmd_valid <= 1'b0;
                        cmd_code  <= CMD_NONE;
                        issued    <= (issued >= MAX_ISSUED) ? issued : issued + 4'd1;
                        state     <= SELECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
